credit_tx_endpoint: RTL and testbench
=====================================

Name: credit_tx_endpoint

Overview:
Transmit-side endpoint of the credit-based rank-to-rank message link. It is the counterpart of the receive endpoint that grants credits.
- Accepts 64-bit messages from local logic, buffers them in a small FIFO.
- Launches one message per available credit toward the DPI send bridge.
- Replenishes credits from credit-return pulses issued by the remote receiver.
- Sits between the local traffic source and the DPI snd() bridge in each rank's communicator.

Parameters:
DATA_W, 64, message payload width
DEPTH, 4, FIFO entries (power of two, >=2)
MAX_CREDIT, 8, credits held after reset; saturation ceiling
CNT_W, 4, width of credit counter (must hold MAX_CREDIT)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
in_valid  input  1  local message valid
in_ready  output  1  endpoint can accept (FIFO not full)
in_data  input  DATA_W  local message payload
in_dest  input  32  destination rank for message
my_rank  input  32  this rank, forwarded with each send
snd_valid  output  1  message presented to send bridge
snd_ready  input  1  bridge accepts message
snd_data  output  DATA_W  payload to bridge
snd_dest  output  32  destination rank to bridge
snd_rank  output  32  source rank (registered copy of my_rank at load)
credit_return  input  1  one-cycle pulse: remote freed one buffer slot
credits  output  CNT_W  current credit count
fifo_count  output  clog2(DEPTH)+1  occupied FIFO entries
stalled  output  1  high in WAIT_CREDIT state
credit_err  output  1  sticky: credit_return received while credits==MAX_CREDIT

Behaviour:
- Reset (rst=1 at posedge) values:
  - credits=MAX_CREDIT, FIFO empty, fifo_count=0.
  - snd_valid=0; snd_data, snd_dest and snd_rank all 0.
  - stalled=0, credit_err=0, state IDLE.
  - in_ready=0 during the reset cycle and 1 afterwards.
- Reset mid-operation discards the FIFO contents and any held output message. No credit is refunded.
- FIFO:
  - Write when in_valid&&in_ready; entry holds {in_data,in_dest}.
  - in_ready = !full, registered-state based; it does not depend combinationally on pop.
  - Write to a full FIFO cannot occur. Simultaneous push and pop at full is not allowed because in_ready=0.
  - Pointers wrap modulo DEPTH.
- Load condition: load = FIFO non-empty && credits_eff>0, where credits_eff = credits + credit_return.
- On load, in the same clock edge:
  - Pop the FIFO head into the output registers and set snd_rank=my_rank.
  - Decrement credits (the credit is reserved at load).
- State machine:
  - IDLE: snd_valid=0.
    - If load: go to SEND.
    - Else if FIFO non-empty (credits_eff==0): go to WAIT_CREDIT.
  - WAIT_CREDIT: snd_valid=0, stalled=1.
    - If load: go to SEND.
    - If FIFO empty (only reachable via reset): go to IDLE.
  - SEND: snd_valid=1; snd_data/dest/rank stay stable until snd_ready.
    - On snd_valid&&snd_ready with load: reload back-to-back and stay in SEND, with no bubble.
    - On handshake, FIFO non-empty, no credit: go to WAIT_CREDIT, snd_valid=0 next cycle.
    - On handshake, FIFO empty: go to IDLE.
- Latency: a message written into an empty FIFO at edge N, with credit available, gives snd_valid=1 after edge N+1.
- Credit arithmetic per cycle: credits_next = credits + credit_return - load.
  - Simultaneous return and load: credits unchanged.
  - If credits==MAX_CREDIT && credit_return && !load: credits stays MAX_CREDIT and credit_err sets.
  - credits never underflows, because a load requires credits_eff>0.
- credit_err clears only on rst.
- fifo_count = push - pop, updated every cycle.

Test Plan:
- Reset, push 3 messages (data 5,6,7, dest 0), snd_ready=1 constant -> snd_valid first high 2 cycles after first push; data 5,6,7 on consecutive cycles; credits 8->5.
- MAX_CREDIT=2, push 4 messages, no returns -> 2 sent, stalled=1, fifo_count=2; one credit_return pulse -> third message sent next cycle, stalled re-asserts.
- snd_ready held 0 for 5 cycles with snd_valid=1 -> snd_data/dest/rank stable, credits unchanged after the load decrement; release -> handshake completes, next loads.
- credit_return in the same cycle as a load with credits=1 -> credits stays 1, no stall.
- credit_return pulse with credits=8 and FIFO empty -> credits stays 8, credit_err=1 and remains 1 until rst.
- Fill the FIFO (4 entries, snd_ready=0) -> in_ready=0, fifo_count=4. Assert rst -> fifo_count=0, snd_valid=0, credits=8 next cycle.

Source files
------------

// File: rtl/credit_tx_endpoint.sv
// Transmit endpoint of the credit-based rank-to-rank link.
// Buffers local messages in a small FIFO and launches one message per
// available credit toward the send bridge; credits come back as pulses.
module credit_tx_endpoint #(
    parameter int DATA_W     = 64,
    parameter int DEPTH      = 4,
    parameter int MAX_CREDIT = 8,
    parameter int CNT_W      = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [31:0]              in_dest,
    input  logic [31:0]              my_rank,
    output logic                     snd_valid,
    input  logic                     snd_ready,
    output logic [DATA_W-1:0]        snd_data,
    output logic [31:0]              snd_dest,
    output logic [31:0]              snd_rank,
    input  logic                     credit_return,
    output logic [CNT_W-1:0]         credits,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     stalled,
    output logic                     credit_err
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT_CREDIT, SEND} state_t;

    state_t state, state_nxt;

    logic [DATA_W+31:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [AW:0]        count;
    logic               full, empty, push, load, have_credit, can_take;

    assign full        = (count == (AW+1)'(DEPTH));
    assign empty       = (count == '0);
    assign in_ready    = !rst && !full;
    assign push        = in_valid && in_ready;
    // credits_eff > 0 without widening the counter
    assign have_credit = (credits != '0) || credit_return;
    // the output registers may only be overwritten once the held message is gone
    assign can_take    = (state != SEND) || snd_ready;
    assign load        = !empty && have_credit && can_take;

    assign fifo_count  = count;
    assign snd_valid   = (state == SEND);
    assign stalled     = (state == WAIT_CREDIT);

    // FIFO storage, pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {in_data, in_dest};
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (load) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, load})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // credit counter with saturation and sticky overflow flag
    always_ff @(posedge clk) begin
        if (rst) begin
            credits    <= CNT_W'(MAX_CREDIT);
            credit_err <= 1'b0;
        end else begin
            case ({credit_return, load})
                2'b10: begin
                    if (credits == CNT_W'(MAX_CREDIT)) credit_err <= 1'b1;
                    else                               credits    <= credits + CNT_W'(1);
                end
                2'b01:   credits <= credits - CNT_W'(1);
                default: credits <= credits;
            endcase
        end
    end

    // output message registers, loaded from the FIFO head
    always_ff @(posedge clk) begin
        if (rst) begin
            snd_data <= '0;
            snd_dest <= '0;
            snd_rank <= '0;
        end else if (load) begin
            snd_data <= mem[rd_ptr][DATA_W+31:32];
            snd_dest <= mem[rd_ptr][31:0];
            snd_rank <= my_rank;
        end
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (load)        state_nxt = SEND;
                else if (!empty) state_nxt = WAIT_CREDIT;
            end
            WAIT_CREDIT: begin
                if (load)       state_nxt = SEND;
                else if (empty) state_nxt = IDLE;
            end
            SEND: begin
                if (snd_ready) begin
                    if (load)        state_nxt = SEND;
                    else if (!empty) state_nxt = WAIT_CREDIT;
                    else             state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_credit_tx_endpoint.sv
// Self-checking bench: directed scenarios followed by random traffic,
// compared every cycle against a queue-based model of the endpoint.
module tb_credit_tx_endpoint;

    localparam int DATA_W = 64;
    localparam int DEPTH  = 4;
    localparam int MAXC   = 8;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst, in_valid, snd_ready, credit_return;
    logic [DATA_W-1:0] in_data;
    logic [31:0]       in_dest, my_rank;
    logic              in_ready, snd_valid, stalled, credit_err;
    logic [DATA_W-1:0] snd_data;
    logic [31:0]       snd_dest, snd_rank;
    logic [CNT_W-1:0]  credits;
    logic [2:0]        fifo_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    credit_tx_endpoint #(.DATA_W(DATA_W), .DEPTH(DEPTH), .MAX_CREDIT(MAXC), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_dest(in_dest), .my_rank(my_rank),
        .snd_valid(snd_valid), .snd_ready(snd_ready), .snd_data(snd_data),
        .snd_dest(snd_dest), .snd_rank(snd_rank), .credit_return(credit_return),
        .credits(credits), .fifo_count(fifo_count), .stalled(stalled),
        .credit_err(credit_err)
    );

    // Reference model: a message queue, an integer credit pool and the
    // message currently offered to the bridge.
    logic [DATA_W+31:0] q[$];
    logic [DATA_W+31:0] e;
    int                 m_credits;
    bit                 m_valid, m_stalled, m_err;
    logic [DATA_W-1:0]  m_data;
    logic [31:0]        m_dest, m_rank;
    bit                 p_push, p_load, p_nonempty, p_hold;

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_credits = MAXC;
            m_valid = 0; m_stalled = 0; m_err = 0;
            m_data = '0; m_dest = '0; m_rank = '0;
        end else begin
            p_push     = in_valid && (q.size() < DEPTH);
            p_nonempty = (q.size() > 0);
            p_hold     = m_valid && !snd_ready;
            p_load     = p_nonempty && (m_credits > 0 || credit_return) && !p_hold;
            m_stalled  = !p_load && p_nonempty && !p_hold;
            m_valid    = p_load || p_hold;
            if (p_load) begin
                e = q.pop_front();
                m_data = e[DATA_W+31:32];
                m_dest = e[31:0];
                m_rank = my_rank;
            end
            if (p_load && !credit_return) m_credits = m_credits - 1;
            else if (credit_return && !p_load) begin
                if (m_credits == MAXC) m_err = 1;
                else                   m_credits = m_credits + 1;
            end
            if (p_push) q.push_back({in_data, in_dest});
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        check("in_ready",   64'(in_ready),   64'(!rst && q.size() < DEPTH));
        check("snd_valid",  64'(snd_valid),  64'(m_valid));
        check("snd_data",   snd_data,        m_data);
        check("snd_dest",   64'(snd_dest),   64'(m_dest));
        check("snd_rank",   64'(snd_rank),   64'(m_rank));
        check("credits",    64'(credits),    64'(m_credits));
        check("fifo_count", 64'(fifo_count), 64'(q.size()));
        check("stalled",    64'(stalled),    64'(m_stalled));
        check("credit_err", 64'(credit_err), 64'(m_err));
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle_inputs();
        in_valid = 0; credit_return = 0; in_data = '0; in_dest = '0;
    endtask

    int first_valid;

    initial begin
        rst = 1; snd_ready = 1; my_rank = 32'h0000_0003;
        idle_inputs();
        @(negedge clk);
        tick(); tick();
        check("rst_credits", 64'(credits), 64'(MAXC));
        check("rst_in_ready", 64'(in_ready), 64'd0);
        rst = 0;
        tick();

        // three messages with the bridge always ready
        first_valid = -1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1; in_data = 64'(5 + i); in_dest = '0;
            tick();
            if (snd_valid && first_valid < 0) first_valid = i;
        end
        idle_inputs();
        for (int i = 3; i < 8; i++) begin
            tick();
            if (snd_valid && first_valid < 0) first_valid = i;
        end
        check("first_valid_cycle", 64'(first_valid), 64'd1);
        check("credits_after_3", 64'(credits), 64'd5);

        // give back the three credits
        for (int i = 0; i < 3; i++) begin
            credit_return = 1; tick();
            credit_return = 0; tick();
        end

        // exhaust credits, observe stall, then release one at a time
        for (int i = 0; i < 12; i++) begin
            in_valid = 1; in_data = 64'(100 + i); in_dest = 32'(i); my_rank = 32'(i + 40);
            tick();
        end
        idle_inputs();
        tick(); tick();
        check("stall_asserted", 64'(stalled), 64'd1);
        check("stall_credits", 64'(credits), 64'd0);
        credit_return = 1; tick();
        credit_return = 0; tick();
        tick();
        check("stall_reasserted", 64'(stalled), 64'd1);
        for (int i = 0; i < 10; i++) begin
            credit_return = (i % 2 == 0); tick();
        end
        credit_return = 0;

        // bridge back-pressure holds the offered message
        snd_ready = 0;
        in_valid = 1; in_data = 64'hDEAD_BEEF; in_dest = 32'h77; my_rank = 32'h55;
        tick();
        in_valid = 0;
        for (int i = 0; i < 5; i++) tick();
        check("hold_data", snd_data, 64'hDEAD_BEEF);
        check("hold_rank", 64'(snd_rank), 64'h55);
        snd_ready = 1;
        tick(); tick();

        // return credits until saturation triggers the sticky error
        for (int i = 0; i < 12; i++) begin
            credit_return = 1; tick();
        end
        credit_return = 0;
        check("err_set", 64'(credit_err), 64'd1);
        for (int i = 0; i < 4; i++) tick();
        check("err_sticky", 64'(credit_err), 64'd1);

        // fill the FIFO behind a stuck bridge, then reset
        snd_ready = 0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1; in_data = 64'(200 + i); in_dest = 32'(i); tick();
        end
        idle_inputs();
        check("fill_count", 64'(fifo_count), 64'd4);
        check("fill_ready", 64'(in_ready), 64'd0);
        rst = 1; tick();
        rst = 0; tick();
        check("post_rst_count", 64'(fifo_count), 64'd0);
        check("post_rst_valid", 64'(snd_valid), 64'd0);
        check("post_rst_credits", 64'(credits), 64'd8);
        check("post_rst_err", 64'(credit_err), 64'd0);
        snd_ready = 1;

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            rst           = ($urandom_range(0, 199) == 0);
            in_valid      = ($urandom_range(0, 9) < 6);
            in_data       = {$urandom, $urandom};
            in_dest       = $urandom;
            my_rank       = $urandom;
            snd_ready     = ($urandom_range(0, 9) < 7);
            credit_return = ($urandom_range(0, 9) < 2);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
